// File: rtl/mipi_csi2_pkt_ctrl.sv
// rtl/mipi_csi2_pkt_ctrl.sv - CSI-2 HS burst packet sequencer
//
// Parses sync byte, 4-byte packet header, payload and 2-byte CRC from the
// deserialized D-PHY byte stream and drives frame/line valid and payload bytes.
// Optional header ECC check: define MIPI_CSI2_ECC_CHECK_EN.
//
// Ports:
//   clk        byte clock
//   reset      synchronous, active-high
//   in_we      byte valid for the whole HS burst
//   in_data    deserialized byte
//   out_fv     frame valid
//   out_lv     line valid while accepted payload bytes flow
//   out_valid  out_data qualifier
//   out_data   payload byte (one clock after input)
//   out_dt     data type of the current/last long packet
//   line_cnt   long packets accepted since last frame start
//   err_sync   pulse: burst did not start with SYNC_BYTE
//   err_trunc  pulse: in_we fell before the packet completed
//   err_ecc    pulse: header ECC mismatch (tied 0 without the ECC feature)

module mipi_csi2_pkt_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'hB8,
   parameter logic [1:0] VC        = 2'd0,
   parameter int         WC_W      = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_we,
   input  logic [7:0]      in_data,
   output logic            out_fv,
   output logic            out_lv,
   output logic            out_valid,
   output logic [7:0]      out_data,
   output logic [5:0]      out_dt,
   output logic [WC_W-1:0] line_cnt,
   output logic            err_sync,
   output logic            err_trunc,
   output logic            err_ecc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAY,
      S_CRC,
      S_WAIT
   } state_t;

   state_t state, state_nxt;

   logic [1:0]  hdr_idx;
   logic [7:0]  di_q;
   logic [7:0]  wcl_q;
   logic [7:0]  wch_q;
   logic [15:0] byte_cnt;
   logic        crc_idx;

   // Header decode, meaningful only while the ECC byte is on in_data
   logic        hdr_last;
   logic        vc_ok;
   logic        is_long;
   logic [5:0]  dt;
   logic [15:0] wc;
   logic        ecc_bad;

   assign hdr_last = (state == S_HDR) && in_we && (hdr_idx == 2'd3);
   assign vc_ok    = (di_q[7:6] == VC);
   assign dt       = di_q[5:0];
   assign is_long  = (dt[5:4] != 2'b00);
   assign wc       = {wch_q, wcl_q};

`ifdef MIPI_CSI2_ECC_CHECK_EN
   function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   assign ecc_bad = (csi2_ecc({wch_q, wcl_q, di_q}) != in_data[5:0]);
`else
   assign ecc_bad = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (in_we) state_nxt = (in_data == SYNC_BYTE) ? S_HDR : S_WAIT;
         S_HDR: begin
            if (!in_we) begin
               state_nxt = S_IDLE;
            end else if (hdr_idx == 2'd3) begin
               if (ecc_bad || !vc_ok || !is_long) state_nxt = S_WAIT;
               else if (wc == 16'd0)              state_nxt = S_CRC;
               else                               state_nxt = S_PAY;
            end
         end
         S_PAY: begin
            if (!in_we)                  state_nxt = S_IDLE;
            else if (byte_cnt == 16'd1)  state_nxt = S_CRC;
         end
         S_CRC: begin
            if (!in_we)       state_nxt = S_IDLE;
            else if (crc_idx) state_nxt = S_WAIT;
         end
         S_WAIT: if (!in_we) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   logic            fv_nxt, lv_nxt, valid_nxt;
   logic [7:0]      data_nxt;
   logic [5:0]      dt_nxt;
   logic [WC_W-1:0] line_nxt;
   logic            sync_nxt, trunc_nxt, ecc_nxt;

   always_comb begin
      fv_nxt    = out_fv;
      lv_nxt    = 1'b0;
      valid_nxt = 1'b0;
      data_nxt  = out_data;
      dt_nxt    = out_dt;
      line_nxt  = line_cnt;
      sync_nxt  = 1'b0;
      trunc_nxt = 1'b0;
      ecc_nxt   = 1'b0;
      case (state)
         S_IDLE: sync_nxt = in_we && (in_data != SYNC_BYTE);
         S_HDR: begin
            if (!in_we) begin
               trunc_nxt = 1'b1;
            end else if (hdr_last) begin
               if (ecc_bad) begin
                  ecc_nxt = 1'b1;
               end else if (vc_ok) begin
                  if (is_long) begin
                     dt_nxt = dt;
                  end else if (dt == 6'h00) begin
                     // Frame start also restarts a frame already in progress
                     fv_nxt   = 1'b1;
                     line_nxt = '0;
                  end else if (dt == 6'h01) begin
                     fv_nxt = 1'b0;
                  end
               end
            end
         end
         S_PAY: begin
            if (in_we) begin
               lv_nxt    = 1'b1;
               valid_nxt = 1'b1;
               data_nxt  = in_data;
            end else begin
               trunc_nxt = 1'b1;
            end
         end
         S_CRC: begin
            if (!in_we)       trunc_nxt = 1'b1;
            else if (crc_idx) line_nxt  = line_cnt + WC_W'(1);
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         out_fv    <= 1'b0;
         out_lv    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_dt    <= 6'h00;
         line_cnt  <= '0;
         err_sync  <= 1'b0;
         err_trunc <= 1'b0;
         err_ecc   <= 1'b0;
      end else begin
         out_fv    <= fv_nxt;
         out_lv    <= lv_nxt;
         out_valid <= valid_nxt;
         out_data  <= data_nxt;
         out_dt    <= dt_nxt;
         line_cnt  <= line_nxt;
         err_sync  <= sync_nxt;
         err_trunc <= trunc_nxt;
         err_ecc   <= ecc_nxt;
      end
   end

   // Header capture and byte counters
   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_idx  <= 2'd0;
         di_q     <= 8'h00;
         wcl_q    <= 8'h00;
         wch_q    <= 8'h00;
         byte_cnt <= 16'd0;
         crc_idx  <= 1'b0;
      end else begin
         if (state != S_HDR)  hdr_idx <= 2'd0;
         else if (in_we)      hdr_idx <= hdr_idx + 2'd1;

         if ((state == S_HDR) && in_we) begin
            case (hdr_idx)
               2'd0:    di_q  <= in_data;
               2'd1:    wcl_q <= in_data;
               2'd2:    wch_q <= in_data;
               default: ;
            endcase
         end

         if (hdr_last)                        byte_cnt <= wc;
         else if ((state == S_PAY) && in_we)  byte_cnt <= byte_cnt - 16'd1;

         if (state != S_CRC)  crc_idx <= 1'b0;
         else if (in_we)      crc_idx <= 1'b1;
      end
   end

endmodule
